// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM resolution default and duty-decoder FSM states
package pwm_pkg;
    localparam int DEFAULT_PWM_RESOLUTION_BITS = 8;
    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider, one quotient bit per cycle MSB first, computing floor(hi*2^N/per) for hi<per
module pwm_duty_div #(
    parameter int N        = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                CLK_IP,
    input  logic                RST_IP,
    input  logic                i_abort,
    input  logic                i_start,
    input  logic [CNT_BITS-1:0] i_hi,
    input  logic [CNT_BITS-1:0] i_per,
    output logic                o_busy,
    output logic                o_done,
    output logic [N-1:0]        o_quot
);
    localparam int CW = $clog2(N + 1);
    logic [CNT_BITS-1:0] r_rem, r_per;
    logic [N-2:0]        r_q;
    logic [CW-1:0]       r_left;
    logic [CNT_BITS:0]   w_sh;
    logic                w_bit;
    assign w_sh   = {r_rem, 1'b0};
    assign w_bit  = w_sh >= {1'b0, r_per};
    assign o_done = o_busy && r_left == CW'(1);
    assign o_quot = {r_q, w_bit};
    // Remainder stays below per, so it always fits CNT_BITS after the restore step
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) begin
            o_busy <= 1'b0;
            r_left <= '0;
            r_rem  <= '0;
            r_per  <= '0;
            r_q    <= '0;
        end else if (i_abort)
            o_busy <= 1'b0;
        else if (i_start && !o_busy) begin
            o_busy <= 1'b1;
            r_left <= CW'(N);
            r_rem  <= i_hi;
            r_per  <= i_per;
            r_q    <= '0;
        end else if (o_busy) begin
            o_busy <= !o_done;
            r_left <= r_left - 1'b1;
            r_rem  <= CNT_BITS'(w_bit ? w_sh - {1'b0, r_per} : w_sh);
            r_q    <= o_quot[N-2:0];
        end
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time, period and normalised duty of an asynchronous PWM input
module pwm_duty_decoder #(
    parameter int PWM_RESOLUTION_BITS = pwm_pkg::DEFAULT_PWM_RESOLUTION_BITS,
    parameter int CNT_BITS            = 16
) (
    input  logic                           CLK_IP,
    input  logic                           RST_IP,
    input  logic                           enable_i,
    input  logic                           pwm_i,
    output logic [PWM_RESOLUTION_BITS-1:0] duty_o,
    output logic [CNT_BITS-1:0]            high_cnt_o,
    output logic [CNT_BITS-1:0]            period_cnt_o,
    output logic                           valid_o,
    output logic                           stuck_o,
    output logic                           level_o,
    output logic                           overrun_o
);
    import pwm_pkg::*;
    localparam int N = PWM_RESOLUTION_BITS;
    localparam logic [CNT_BITS-1:0] MAX_CNT = '1;
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);
    state_t              r_state, w_next;
    logic                r_meta, r_s, r_s_d;
    logic [CNT_BITS-1:0] r_hi_cnt, r_per_cnt, r_cap_hi, r_cap_per;
    logic                w_rise, w_fall, w_timeout, w_capture, w_start, w_abort, w_busy, w_done;
    logic [N-1:0]        w_quot;
    assign w_rise  = r_s & ~r_s_d;
    assign w_fall  = ~r_s & r_s_d;
    assign w_abort = ~enable_i;
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) {r_meta, r_s, r_s_d} <= '0;
        else {r_meta, r_s, r_s_d} <= {pwm_i, r_meta, r_s};
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (!enable_i) w_next = IDLE;
        else if (w_timeout) w_next = WAIT_RISE;
        else
            case (r_state)
                IDLE:      w_next = WAIT_RISE;
                WAIT_RISE: w_next = w_rise ? HIGH : WAIT_RISE;
                HIGH:      w_next = w_fall ? LOW : HIGH;
                LOW:       w_next = w_rise ? HIGH : LOW;
                default:   w_next = IDLE;
            endcase
    end
    always_comb begin
        w_timeout = enable_i && r_state != IDLE && r_per_cnt == MAX_CNT;
        w_capture = enable_i && r_state == LOW && w_rise && !w_timeout;
        w_start   = w_capture && !w_busy;
        overrun_o = w_capture && w_busy;
    end
    // The rise cycle is the first high cycle of the new period, so both counters restart at 1
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) begin
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
        end else if (!enable_i || r_state == IDLE || w_timeout) begin
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
        end else if (w_rise && r_state != HIGH) begin
            r_hi_cnt  <= ONE;
            r_per_cnt <= ONE;
        end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
            if (r_state == HIGH && !w_fall) r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) begin
            r_cap_hi  <= '0;
            r_cap_per <= '0;
        end else if (w_start) begin
            r_cap_hi  <= r_hi_cnt;
            r_cap_per <= r_per_cnt;
        end
    pwm_duty_div #(.N(N), .CNT_BITS(CNT_BITS)) u_div (
        .CLK_IP  (CLK_IP),
        .RST_IP  (RST_IP),
        .i_abort (w_abort),
        .i_start (w_start),
        .i_hi    (r_hi_cnt),
        .i_per   (r_per_cnt),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_quot  (w_quot)
    );
    always_ff @(posedge CLK_IP or posedge RST_IP)
        if (RST_IP) begin
            valid_o      <= 1'b0;
            stuck_o      <= 1'b0;
            level_o      <= 1'b0;
            duty_o       <= '0;
            high_cnt_o   <= '0;
            period_cnt_o <= '0;
        end else if (w_done && enable_i) begin
            valid_o      <= 1'b1;
            stuck_o      <= 1'b0;
            duty_o       <= w_quot;
            high_cnt_o   <= r_cap_hi;
            period_cnt_o <= r_cap_per;
        end else if (w_timeout) begin
            valid_o      <= 1'b1;
            stuck_o      <= 1'b1;
            level_o      <= r_s;
            duty_o       <= {N{r_s}};
            high_cnt_o   <= {CNT_BITS{r_s}};
            period_cnt_o <= MAX_CNT;
        end else
            valid_o <= 1'b0;
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Measures an incoming PWM waveform: high time, period and normalised duty cycle.
- The result is directly comparable to the duty_cycle value fed to the team's PWM generators.
- Used for LED-loopback self-test of the RGB PWM outputs and for decoding external PWM inputs on the EOS S3 fabric.
- Runs on the fabric clock CLK_IP; the PWM input is asynchronous to it.

Parameters:
PWM_RESOLUTION_BITS, 8, width N of duty_o; duty = floor(high*2^N/period)
CNT_BITS, 16, width of high/period counters; timeout at 2^CNT_BITS-1 cycles; require 2^CNT_BITS-1 > N+2

Ports:
CLK_IP  in  1  fabric clock
RST_IP  in  1  reset, asynchronous, active-high; clock CLK_IP
enable_i  in  1  measurement enable, synchronous
pwm_i  in  1  asynchronous PWM input
duty_o  out  N  last decoded duty
high_cnt_o  out  CNT_BITS  last measured high cycles
period_cnt_o  out  CNT_BITS  last measured period cycles
valid_o  out  1  one-cycle pulse; duty_o/high_cnt_o/period_cnt_o updated this cycle
stuck_o  out  1  input static for a full timeout
level_o  out  1  input level at last timeout
overrun_o  out  1  one-cycle pulse; completed period dropped because divider busy

Behaviour:
- Reset (async):
  - All outputs 0.
  - Synchroniser flops 0.
  - FSM in IDLE; counters 0; divider idle.
- Input conditioning:
  - 2-flop synchroniser gives s; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Pin-to-s latency is 2 cycles.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW.
  - IDLE: enable_i=1 -> WAIT_RISE, per_cnt=0.
  - WAIT_RISE: per_cnt++ each cycle. On rise -> HIGH with hi_cnt=1, per_cnt=1.
  - HIGH: hi_cnt++ and per_cnt++ each cycle. On fall -> LOW; the fall cycle counts in per_cnt only.
  - LOW: per_cnt++. On rise: capture (hi_cnt, per_cnt), request divide, -> HIGH with hi_cnt=1, per_cnt=1.
  - Result: input high H cycles, low L cycles gives hi=H, per=H+L.
- enable_i=0 in any state:
  - -> IDLE next cycle; counters cleared; in-flight divide aborted with no valid_o.
  - Outputs hold their last values.
- Divider (pwm_duty_div):
  - Restoring, 1 quotient bit per cycle, MSB first: rem<<=1; if rem>=per {rem-=per; bit=1}.
  - Initial rem = hi. hi<per always holds, so the quotient fits N bits; no saturation path.
- Latency: rise captured at cycle t -> divider busy t+1..t+N -> valid_o=1 at t+N+1.
  - duty_o, high_cnt_o and period_cnt_o all update at t+N+1.
  - stuck_o clears at t+N+1.
- Overrun: a capture while the divider is busy is dropped and overrun_o pulses that cycle. The FSM continues measuring. Minimum loss-free period is N+1 cycles.
- Timeout: per_cnt reaching 2^CNT_BITS-1 in WAIT_RISE, HIGH or LOW:
  - valid_o pulse; stuck_o=1; level_o=s.
  - duty_o = s ? 2^N-1 : 0.
  - high_cnt_o = s ? all-ones : 0; period_cnt_o = all-ones.
  - -> WAIT_RISE with per_cnt=0.
  - Repeats every 2^CNT_BITS-1 cycles while the input stays static.
- Timeout and divide completion cannot coincide, given the CNT_BITS constraint.
- Counters never wrap; the timeout pre-empts overflow.
- Reset mid-measurement: all state returns to reset values immediately. The first valid_o after release requires a complete rise-to-rise period.

Decomposition:
- Shared package pwm_pkg:
  - PWM_RESOLUTION_BITS default (8), shared with the PWM generators.
  - FSM state enum {IDLE, WAIT_RISE, HIGH, LOW}.
- Sub-module pwm_duty_div:
  - Ports: start, hi, per -> busy, done, quotient.
  - Parameters N, CNT_BITS.
- Top holds the synchroniser, edge detect, FSM, counters and output registers.

Test Plan:
- N=8, enable=1, H=20/L=236 repeated -> valid_o every 256 cycles; duty_o=20, high_cnt_o=20, period_cnt_o=256; stuck_o=0.
- H=150/L=106 -> duty_o=150. H=100/L=200 -> duty_o=85, period_cnt_o=300. Check valid_o exactly N+1=9 cycles after the synchronised rise.
- H=2/L=3 (period 5) -> first capture duty_o=102; next capture (5 cycles later, divider busy) -> overrun_o pulse, no valid_o; following capture accepted.
- pwm_i held 1 after enable -> valid_o at per_cnt 65535 with stuck_o=1, level_o=1, duty_o=255, period_cnt_o=65535. Then toggling H=20/L=236 -> stuck_o=0 on next valid_o.
- Assert RST_IP mid-HIGH -> all outputs 0 same cycle. After release, no valid_o until one full period completes.
- Drop enable_i during a divide -> no valid_o, outputs hold previous values. Re-enable -> WAIT_RISE, correct result after the second rise.
